// File: rtl/rx_ipg_demux_pkg.sv
// rtl/rx_ipg_demux_pkg.sv - shared sync header encodings, block types and frame helpers
package rx_ipg_demux_pkg;

    // Chunk encodings reuse the two sync headers that are illegal on a plain 64b/66b link.
    localparam logic [1:0] SYNC_DATA = 2'b10;
    localparam logic [1:0] SYNC_CTRL = 2'b01;
    localparam logic [1:0] SYNC_MEM  = 2'b11;
    localparam logic [1:0] SYNC_REQ  = 2'b00;

    localparam logic [7:0] BLOCK_TYPE_S0      = 8'h78;
    localparam logic [7:0] BLOCK_TYPE_S4_IDLE = 8'h33;
    localparam logic [7:0] BLOCK_TYPE_S4_ORD  = 8'h66;
    localparam logic [7:0] BLOCK_TYPE_T0      = 8'h87;
    localparam logic [7:0] BLOCK_TYPE_T1      = 8'h99;
    localparam logic [7:0] BLOCK_TYPE_T2      = 8'haa;
    localparam logic [7:0] BLOCK_TYPE_T3      = 8'hb4;
    localparam logic [7:0] BLOCK_TYPE_T4      = 8'hcc;
    localparam logic [7:0] BLOCK_TYPE_T5      = 8'hd2;
    localparam logic [7:0] BLOCK_TYPE_T6      = 8'he1;
    localparam logic [7:0] BLOCK_TYPE_T7      = 8'hff;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FRAME = 1'b1
    } frame_state_t;

    function automatic logic is_start(input logic [7:0] block_type);
        return (block_type == BLOCK_TYPE_S0) ||
               (block_type == BLOCK_TYPE_S4_IDLE) ||
               (block_type == BLOCK_TYPE_S4_ORD);
    endfunction

    function automatic logic is_term(input logic [7:0] block_type);
        return (block_type == BLOCK_TYPE_T0) || (block_type == BLOCK_TYPE_T1) ||
               (block_type == BLOCK_TYPE_T2) || (block_type == BLOCK_TYPE_T3) ||
               (block_type == BLOCK_TYPE_T4) || (block_type == BLOCK_TYPE_T5) ||
               (block_type == BLOCK_TYPE_T6) || (block_type == BLOCK_TYPE_T7);
    endfunction

endpackage

// File: rtl/rx_chunk_fifo.sv
// rtl/rx_chunk_fifo.sv - 64-bit show-ahead chunk FIFO with empty/full/space status
module rx_chunk_fifo #(
    parameter int DEPTH   = 8,
    parameter int SPACE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_en,
    input  logic [63:0]        wr_data,
    input  logic               rd_en,
    output logic [63:0]        rd_data,
    output logic               empty,
    output logic               full,
    output logic [SPACE_W-1:0] space
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [63:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic          do_wr;
    logic          do_rd;

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));
    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;

    // Stale storage is hidden so the head reads zero whenever nothing is queued.
    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_comb begin
        count_next = count;
        case ({do_wr, do_rd})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            space  <= SPACE_W'(DEPTH);
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_next;
            space <= SPACE_W'(DEPTH) - SPACE_W'(count_next);
        end
    end

endmodule

// File: rtl/rx_ipg_demux.sv
// rtl/rx_ipg_demux.sv - splits network blocks from IPG-carried memory/request chunks
module rx_ipg_demux
    import rx_ipg_demux_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int SPACE_W = 4,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [63:0]        rx_data,
    input  logic [1:0]         rx_hdr,
    input  logic               rx_valid,
    output logic [63:0]        net_data,
    output logic [1:0]         net_hdr,
    output logic               net_valid,
    output logic               net_fin,
    input  logic               mem_rd,
    output logic [63:0]        mem_data,
    output logic               mem_empty,
    output logic [SPACE_W-1:0] mem_space,
    input  logic               req_rd,
    output logic [63:0]        req_data,
    output logic               req_empty,
    output logic [SPACE_W-1:0] req_space,
    output logic               in_frame,
    output logic               err_ipg_in_frame,
    output logic [CNT_W-1:0]   ovf_cnt,
    output logic [CNT_W-1:0]   frame_err_cnt
);

    frame_state_t state;
    frame_state_t state_next;
    logic [7:0]   block_type;
    logic         is_net;
    logic         is_fin;
    logic         mem_full;
    logic         req_full;
    logic         mem_wr;
    logic         req_wr;
    logic         ovf_inc;
    logic         frame_err_inc;
    logic         ipg_err;

    assign block_type = rx_data[7:0];
    assign is_net     = rx_valid && ((rx_hdr == SYNC_DATA) || (rx_hdr == SYNC_CTRL));
    assign is_fin     = rx_valid && (rx_hdr == SYNC_CTRL) && is_term(block_type);
    assign in_frame   = (state == ST_FRAME);

    always_comb begin
        state_next    = state;
        mem_wr        = 1'b0;
        req_wr        = 1'b0;
        ovf_inc       = 1'b0;
        frame_err_inc = 1'b0;
        ipg_err       = 1'b0;
        if (rx_valid) begin
            unique case (rx_hdr)
                SYNC_CTRL: begin
                    if (state == ST_IDLE) begin
                        if (is_start(block_type)) state_next = ST_FRAME;
                    end else if (is_start(block_type)) begin
                        frame_err_inc = 1'b1;
                    end else if (is_term(block_type)) begin
                        state_next = ST_IDLE;
                    end
                end
                SYNC_DATA: begin
                    if (state == ST_IDLE) frame_err_inc = 1'b1;
                end
                // Chunks only belong in the gap; fullness is judged on the pre-edge level.
                SYNC_MEM: begin
                    if (state == ST_FRAME) ipg_err = 1'b1;
                    else if (mem_full)     ovf_inc = 1'b1;
                    else                   mem_wr  = 1'b1;
                end
                SYNC_REQ: begin
                    if (state == ST_FRAME) ipg_err = 1'b1;
                    else if (req_full)     ovf_inc = 1'b1;
                    else                   req_wr  = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= ST_IDLE;
            net_data         <= '0;
            net_hdr          <= '0;
            net_valid        <= 1'b0;
            net_fin          <= 1'b0;
            err_ipg_in_frame <= 1'b0;
            ovf_cnt          <= '0;
            frame_err_cnt    <= '0;
        end else begin
            state            <= state_next;
            net_valid        <= is_net;
            net_fin          <= is_fin;
            err_ipg_in_frame <= ipg_err;
            if (is_net) begin
                net_data <= rx_data;
                net_hdr  <= rx_hdr;
            end
            if (ovf_inc && (ovf_cnt != '1)) begin
                ovf_cnt <= ovf_cnt + CNT_W'(1);
            end
            if (frame_err_inc && (frame_err_cnt != '1)) begin
                frame_err_cnt <= frame_err_cnt + CNT_W'(1);
            end
        end
    end

    rx_chunk_fifo #(
        .DEPTH   (DEPTH),
        .SPACE_W (SPACE_W)
    ) u_mem_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (mem_wr),
        .wr_data (rx_data),
        .rd_en   (mem_rd),
        .rd_data (mem_data),
        .empty   (mem_empty),
        .full    (mem_full),
        .space   (mem_space)
    );

    rx_chunk_fifo #(
        .DEPTH   (DEPTH),
        .SPACE_W (SPACE_W)
    ) u_req_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (req_wr),
        .wr_data (rx_data),
        .rd_en   (req_rd),
        .rd_data (req_data),
        .empty   (req_empty),
        .full    (req_full),
        .space   (req_space)
    );

endmodule

// File: doc/rx_ipg_demux.md
Name: rx_ipg_demux

Overview:
- Receive-side counterpart of the TX IPG merge path (mem/req/net queues plus buffer monitor).
- Takes the descrambled 66-bit block stream from the PCS and separates ordinary network frame blocks from memory-reply and request chunks that were carried in the inter-packet gap.
- Forwards network blocks toward the MAC with one cycle of latency.
- Buffers memory-reply and request chunks in two internal FIFOs for the EDM memory and request consumers.

Parameters:
- DEPTH, 8: entries per chunk FIFO; must be a power of 2.
- SPACE_W, 4: width of the space outputs; must satisfy 2^SPACE_W > DEPTH.
- CNT_W, 16: width of the saturating error counters.

Ports:
- clk  in  1  sole clock.
- reset  in  1  synchronous, active-high reset.
- rx_data  in  64  incoming block payload; byte 0 is rx_data[7:0].
- rx_hdr  in  2  sync header of the incoming block.
- rx_valid  in  1  qualifies rx_data and rx_hdr.
- net_data  out  64  forwarded network block payload.
- net_hdr  out  2  forwarded network block header.
- net_valid  out  1  net_data and net_hdr are valid this cycle.
- net_fin  out  1  pulses with the forwarded terminate block.
- mem_rd  in  1  pop the memory-reply FIFO.
- mem_data  out  64  head of the memory-reply FIFO (show-ahead).
- mem_empty  out  1  memory-reply FIFO is empty.
- mem_space  out  SPACE_W  free entries in the memory-reply FIFO.
- req_rd  in  1  pop the request FIFO.
- req_data  out  64  head of the request FIFO (show-ahead).
- req_empty  out  1  request FIFO is empty.
- req_space  out  SPACE_W  free entries in the request FIFO.
- in_frame  out  1  frame state machine is in FRAME.
- err_ipg_in_frame  out  1  one-cycle pulse when a chunk arrives in FRAME.
- ovf_cnt  out  CNT_W  saturating count of chunks dropped because a FIFO was full.
- frame_err_cnt  out  CNT_W  saturating count of framing errors.

Behaviour:
- Block classification, applied only when rx_valid=1:
  - 2'b10 (SYNC_DATA) is a network data block.
  - 2'b01 (SYNC_CTRL) is a network control block.
  - 2'b11 is a memory-reply chunk.
  - 2'b00 is a request chunk.
  - Encodings for 2'b11 and 2'b00 are fixed and must match the TX merge path.
- Frame state machine has states IDLE and FRAME.
  - IDLE -> FRAME on a control block with type 0x78, 0x33 or 0x66.
  - FRAME -> IDLE on a control block with type 0x87, 0x99, 0xaa, 0xb4, 0xcc, 0xd2, 0xe1 or 0xff.
  - A start block seen while in FRAME keeps the state in FRAME and increments frame_err_cnt.
  - A data block seen while in IDLE is still forwarded and increments frame_err_cnt.
- Network path:
  - Every network block is registered once: net_valid, net_data and net_hdr follow the input by exactly 1 cycle.
  - net_fin=1 in the same cycle as the forwarded terminate block.
  - Chunks are never forwarded; net_valid=0 in the cycle after a chunk or after rx_valid=0.
- Chunk path:
  - In IDLE, a chunk is written to its FIFO at the clock edge of acceptance and is visible on mem_data/req_data with empty deasserted 1 cycle later.
  - In FRAME, a chunk is dropped and err_ipg_in_frame pulses 1 cycle later; the frame state is unchanged.
  - Full-FIFO check uses the pre-edge fill level: if the FIFO is full, the chunk is dropped and ovf_cnt increments, even if a read happens in the same cycle.
- FIFO handshake:
  - A read with empty=0 pops the head; a read with empty=1 is ignored.
  - Simultaneous read and write when not full leaves the count unchanged.
  - space = DEPTH - count, updated registered.
  - Pointers wrap modulo DEPTH.
- Counters saturate at all-ones.
- Reset values: all outputs 0 except mem_empty=1, req_empty=1, mem_space=DEPTH, req_space=DEPTH. Both FIFOs are flushed and the state machine returns to IDLE.
- Reset asserted mid-frame or mid-write wins over any same-cycle write or read.

Decomposition:
- Shared package holds:
  - SYNC_DATA/SYNC_CTRL/SYNC_MEM/SYNC_REQ encodings.
  - BLOCK_TYPE_* constants.
  - Frame state enum.
  - is_start and is_term helper functions; the TX merge logic reuses these.
- One sub-module, rx_chunk_fifo: 64-bit show-ahead FIFO of depth DEPTH with empty, full and space outputs, instantiated twice (memory-reply and request).

Test Plan:
- Start block 0x78, two data blocks, term 0x87 -> four net_valid cycles at 1-cycle latency; net_fin on the 4th; in_frame 1 then 0.
- In IDLE, hdr 2'b11 data 0x1111_1111_1111_1111, then hdr 2'b00 0x0bbb_bbbb_bccc -> mem_data and req_data show those values next cycle; each space=7; net_valid stays 0.
- Chunk 2'b11 after start 0x33 -> err_ipg_in_frame pulse; mem_empty stays 1; net path unaffected.
- Nine mem chunks in IDLE with mem_rd=0 -> mem_space reaches 0; 9th dropped; ovf_cnt=1. Then full+read+write same cycle -> write dropped, ovf_cnt=2, space=1.
- Reset asserted in FRAME with 3 entries in the req FIFO -> next cycle in_frame=0, req_empty=1, req_space=8, counters 0.
